// File: rtl/map_bram_reader_if.sv
// RAM read port plus outgoing valid/ready word stream of the BRAM read sequencer.
// The master side is the sequencer; the slave side is the RAM and the map datapath.
interface map_bram_reader_if #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_DEPTH = 2
);
    logic [C_LOG_DEPTH-1:0] o_raddr;
    logic                   o_ce;
    logic [C_WIDTH-1:0]     i_rdata;
    logic [C_WIDTH-1:0]     o_data;
    logic                   o_valid;
    logic                   i_ready;

    modport master (
        output o_raddr,
        output o_ce,
        input  i_rdata,
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_raddr,
        input  o_ce,
        output i_rdata,
        input  o_data,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/map_bram_reader.sv
// Reads a run of consecutive (wrapping) words from a 1-cycle-latency BRAM and
// streams them out through a 2-entry FIFO with full backpressure.
module map_bram_reader #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_DEPTH = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [C_LOG_DEPTH-1:0] i_base_addr,
    input  logic [C_LOG_DEPTH:0]   i_count,
    output logic                   o_busy,
    output logic                   o_done,
    map_bram_reader_if.master      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [C_LOG_DEPTH-1:0] addr_reg, addr_next;
    logic [C_LOG_DEPTH:0]   remaining_reg, remaining_next;
    logic                   inflight_reg;
    logic [C_WIDTH-1:0]     fifo_mem_reg [2];
    logic                   wr_ptr_reg, rd_ptr_reg;
    logic [1:0]             occ_reg, occ_next;

    logic       push, pop, ce;
    logic [2:0] level, limit;

    assign push = inflight_reg;
    assign pop  = bus.o_valid & bus.i_ready;

    // Reserve a FIFO slot for every read in flight; a pop this cycle frees one.
    assign level = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign limit = 3'd2 + {2'b00, pop};
    assign ce    = (state_reg == ST_READ) && (remaining_reg != '0) && (level < limit);

    assign bus.o_ce    = ce;
    assign bus.o_raddr = addr_reg;
    assign bus.o_valid = (occ_reg != 2'd0);
    assign bus.o_data  = fifo_mem_reg[rd_ptr_reg];

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        o_busy         = 1'b0;
        o_done         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    o_busy         = 1'b1;
                    addr_next      = i_base_addr;
                    remaining_next = i_count;
                    state_next     = (i_count == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                o_busy = 1'b1;
                if (ce) begin
                    addr_next      = addr_reg + 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (remaining_reg == {{C_LOG_DEPTH{1'b0}}, 1'b1}) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                // Leave as the last word is accepted so o_done lands the next cycle.
                if (!inflight_reg && (occ_next == 2'd0)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done     = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            inflight_reg  <= ce;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_reg[i] <= '0;
            end
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem_reg[wr_ptr_reg] <= bus.i_rdata;
                wr_ptr_reg               <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            occ_reg <= occ_next;
        end
    end

endmodule
